// File: rtl/segment_sched_ctrl_pkg.sv
// Shared definitions for the segment scheduler: FSM states, default sizing
// and reference-table bank selects.
package segment_sched_ctrl_pkg;

  localparam int unsigned NSEG_DEF = 8;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned LAT_DEF  = 2;

  localparam logic IF_BANK   = 1'b0;
  localparam logic ELSE_BANK = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

endpackage

// File: rtl/segment_sched_ctrl_tag_pipe.sv
// seg_tag_pipe: LAT-deep (valid, idx) delay line that travels alongside each
// datapath issue so the returning result can be steered to its buffer slot.
//   clk, reset         : clock, async active-high reset
//   in_valid, in_idx   : tag entering with the issue strobe
//   out_valid, out_idx : tag aligned with the datapath result
//   pending_c          : a tag is still in flight beyond the exiting one
module seg_tag_pipe #(
  parameter int unsigned LAT = 2,
  parameter int unsigned IW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic          pending_c
);

  logic [LAT-1:0] vld;
  logic [IW-1:0]  idx [LAT];

  // Shift register; stage 0 takes the newly issued tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < int'(LAT); i++) idx[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_idx;
      for (int i = 1; i < int'(LAT); i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_idx   = idx[LAT-1];

  // Everything except the last stage still needs a cycle to land.
  always_comb begin
    pending_c = in_valid;
    for (int i = 0; i < int'(LAT) - 1; i++) pending_c = pending_c | vld[i];
  end

endmodule

// File: rtl/segment_sched_ctrl.sv
// Segment scheduler: issues NSEG segments of a job to a shared fixed-latency
// if/else datapath, collects results into a buffer, then streams them out.
//   clk, reset                 : clock, async active-high reset
//   tbl_wr/sel/idx/data        : reference table write port (IDLE only)
//   start, cond_word           : job start pulse and condition word
//   busy                       : job in progress
//   dp_issue, dp_*_ref, dp_cond: datapath issue interface
//   dp_result                  : datapath result, LAT cycles after dp_issue
//   res_valid/ready/idx/data   : result stream
module segment_sched_ctrl
  import segment_sched_ctrl_pkg::*;
#(
  parameter int unsigned NSEG = NSEG_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned LAT  = LAT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tbl_wr,
  input  logic                     tbl_sel,
  input  logic [$clog2(NSEG)-1:0]  tbl_idx,
  input  logic [DW-1:0]            tbl_data,
  input  logic                     start,
  input  logic [DW-1:0]            cond_word,
  output logic                     busy,
  output logic                     dp_issue,
  output logic [DW-1:0]            dp_if_ref,
  output logic [DW-1:0]            dp_else_ref,
  output logic [DW-1:0]            dp_cond,
  input  logic [DW-1:0]            dp_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(NSEG)-1:0]  res_idx,
  output logic [DW-1:0]            res_data
);

  localparam int unsigned IW = $clog2(NSEG);

  state_e        state_q, state_d;
  logic [IW-1:0] iss_cnt_q, iss_cnt_d;
  logic [IW-1:0] out_cnt_d;
  logic          issue_d, res_valid_d, cond_ld, tbl_we;
  logic [DW-1:0] if_ref_d, else_ref_d, res_data_d;

  logic [DW-1:0] if_tbl   [NSEG];
  logic [DW-1:0] else_tbl [NSEG];
  logic [DW-1:0] res_buf  [NSEG];

  logic          tag_valid, pending_c;
  logic [IW-1:0] tag_idx;

  seg_tag_pipe #(.LAT(LAT), .IW(IW)) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (dp_issue),
    .in_idx    (iss_cnt_q),
    .out_valid (tag_valid),
    .out_idx   (tag_idx),
    .pending_c (pending_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    iss_cnt_d   = iss_cnt_q;
    out_cnt_d   = res_idx;
    issue_d     = 1'b0;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    cond_ld     = 1'b0;
    tbl_we      = 1'b0;
    if_ref_d    = '0;
    else_ref_d  = '0;

    case (state_q)
      IDLE: begin
        tbl_we = tbl_wr;
        if (start) begin
          state_d   = ISSUE;
          iss_cnt_d = '0;
          out_cnt_d = '0;
          issue_d   = 1'b1;
          cond_ld   = 1'b1;
        end
      end
      ISSUE: begin
        if (iss_cnt_q == IW'(NSEG - 1)) begin
          state_d = DRAIN;
        end else begin
          iss_cnt_d = IW'(iss_cnt_q + 1'b1);
          issue_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (!pending_c) begin
          state_d     = OUTPUT;
          out_cnt_d   = '0;
          res_valid_d = 1'b1;
          res_data_d  = res_buf[0];
        end
      end
      OUTPUT: begin
        if (res_valid && res_ready) begin
          if (res_idx == IW'(NSEG - 1)) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
          end else begin
            out_cnt_d  = IW'(res_idx + 1'b1);
            res_data_d = res_buf[IW'(res_idx + 1'b1)];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // First segment is loaded on the start edge, so forward a same-cycle table write.
    if (issue_d) begin
      if_ref_d   = (tbl_we && tbl_sel == IF_BANK && tbl_idx == iss_cnt_d)
                   ? tbl_data : if_tbl[iss_cnt_d];
      else_ref_d = (tbl_we && tbl_sel == ELSE_BANK && tbl_idx == iss_cnt_d)
                   ? tbl_data : else_tbl[iss_cnt_d];
    end
  end

  // State, output registers, reference table and result buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      iss_cnt_q   <= '0;
      res_idx     <= '0;
      busy        <= 1'b0;
      dp_issue    <= 1'b0;
      dp_if_ref   <= '0;
      dp_else_ref <= '0;
      dp_cond     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      for (int i = 0; i < int'(NSEG); i++) begin
        if_tbl[i]   <= '0;
        else_tbl[i] <= '0;
        res_buf[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      iss_cnt_q   <= iss_cnt_d;
      res_idx     <= out_cnt_d;
      busy        <= (state_d != IDLE);
      dp_issue    <= issue_d;
      dp_if_ref   <= if_ref_d;
      dp_else_ref <= else_ref_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      if (cond_ld) dp_cond <= cond_word;
      if (tbl_we) begin
        if (tbl_sel == IF_BANK) if_tbl[tbl_idx]   <= tbl_data;
        else                    else_tbl[tbl_idx] <= tbl_data;
      end
      if (tag_valid) res_buf[tag_idx] <= dp_result;
    end
  end

endmodule

// File: tb/tb_segment_sched_ctrl.sv
// Directed bench for segment_sched_ctrl with a datapath model and a
// result scoreboard.
module tb_segment_sched_ctrl;
  import segment_sched_ctrl_pkg::*;

  localparam int unsigned NSEG = NSEG_DEF;
  localparam int unsigned DW   = DW_DEF;
  localparam int unsigned LAT  = LAT_DEF;
  localparam int unsigned IW   = $clog2(NSEG);

  logic          clk, reset;
  logic          tbl_wr, tbl_sel, start, res_ready;
  logic [IW-1:0] tbl_idx;
  logic [DW-1:0] tbl_data, cond_word;
  logic          busy, dp_issue, res_valid;
  logic [DW-1:0] dp_if_ref, dp_else_ref, dp_cond, dp_result, res_data;
  logic [IW-1:0] res_idx;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] if_sh   [NSEG];
  logic [DW-1:0] else_sh [NSEG];
  int            checks = 0;
  int            errors = 0;

  segment_sched_ctrl #(.NSEG(NSEG), .DW(DW), .LAT(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .tbl_wr      (tbl_wr),
    .tbl_sel     (tbl_sel),
    .tbl_idx     (tbl_idx),
    .tbl_data    (tbl_data),
    .start       (start),
    .cond_word   (cond_word),
    .busy        (busy),
    .dp_issue    (dp_issue),
    .dp_if_ref   (dp_if_ref),
    .dp_else_ref (dp_else_ref),
    .dp_cond     (dp_cond),
    .dp_result   (dp_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_idx     (res_idx),
    .res_data    (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: selects a reference by cond bit 0, returns it LAT cycles later.
  logic [DW-1:0] mdl [LAT];
  always @(posedge clk) begin
    mdl[0] <= dp_issue ? (dp_cond[0] ? dp_if_ref : dp_else_ref) : 32'hBAD0_0000;
    for (int i = 1; i < int'(LAT); i++) mdl[i] <= mdl[i-1];
  end
  assign dp_result = mdl[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tbl_write(input logic sel, input int idx, input logic [DW-1:0] data,
                           input bit lands);
    tbl_wr   = 1'b1;
    tbl_sel  = sel;
    tbl_idx  = IW'(idx);
    tbl_data = data;
    tick();
    tbl_wr = 1'b0;
    if (lands) begin
      if (sel == IF_BANK) if_sh[idx] = data;
      else                else_sh[idx] = data;
    end
  endtask

  task automatic load_tables();
    for (int i = 0; i < int'(NSEG); i++) begin
      tbl_write(IF_BANK,   i, DW'(32'h100 + i), 1'b1);
      tbl_write(ELSE_BANK, i, DW'(32'h200 + i), 1'b1);
    end
  endtask

  task automatic push_job(input logic [DW-1:0] cond);
    exp_t e;
    for (int i = 0; i < int'(NSEG); i++) begin
      e.idx  = IW'(i);
      e.data = cond[0] ? if_sh[i] : else_sh[i];
      sb.push_back(e);
    end
  endtask

  task automatic start_job(input logic [DW-1:0] cond);
    cond_word = cond;
    start     = 1'b1;
    push_job(cond);
    tick();
    start = 1'b0;
  endtask

  // Consume NSEG results, optionally stalling at one index and/or spamming start.
  task automatic drain_job(input string tag, input int stall_at, input bit spam);
    exp_t          e;
    logic [IW-1:0] cap_idx;
    logic [DW-1:0] cap_data;
    bit            stable;
    int            w;
    for (int n = 0; n < int'(NSEG); n++) begin
      w = 0;
      if (spam) start = 1'b1;
      while (!res_valid && w < 100) begin
        tick();
        w++;
      end
      check({tag, "_valid"}, 64'(res_valid), 64'd1);
      if (!res_valid || sb.size() == 0) begin
        check({tag, "_sb_nonempty"}, 64'(sb.size()), 64'(NSEG - n));
        start = 1'b0;
        sb.delete();
        return;
      end
      if (n == stall_at) begin
        res_ready = 1'b0;
        cap_idx   = res_idx;
        cap_data  = res_data;
        stable    = 1'b1;
        repeat (20) begin
          tick();
          if (!res_valid || res_idx !== cap_idx || res_data !== cap_data) stable = 1'b0;
        end
        check({tag, "_stall_stable"}, 64'(stable), 64'd1);
        res_ready = 1'b1;
      end
      e = sb.pop_front();
      check({tag, "_idx"},  64'(res_idx),  64'(e.idx));
      check({tag, "_data"}, 64'(res_data), 64'(e.data));
      tick();
    end
    start = 1'b0;
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    reset     = 1'b1;
    tbl_wr    = 1'b0;
    tbl_sel   = 1'b0;
    tbl_idx   = '0;
    tbl_data  = '0;
    start     = 1'b0;
    cond_word = '0;
    res_ready = 1'b1;
    for (int i = 0; i < int'(NSEG); i++) begin
      if_sh[i]   = '0;
      else_sh[i] = '0;
    end
    #1;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_outs",  64'({dp_issue, res_valid, res_idx}), 64'd0);
    check("rst_buses", 64'(dp_if_ref | dp_else_ref | dp_cond | res_data), 64'd0);
    tick(2);
    reset = 1'b0;
    tick();

    // Basic job, if path, with start-to-first-result latency.
    load_tables();
    start_job(32'h1);
    check("busy_rise", 64'(busy), 64'd1);
    lat = 1;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(NSEG + LAT + 1));
    drain_job("job_if", -1, 1'b0);

    // Else path.
    start_job(32'h0);
    drain_job("job_else", -1, 1'b0);

    // Backpressure stall at index 3.
    start_job(32'h1);
    drain_job("stall", 3, 1'b0);

    // Start pulses throughout the job must not queue a second job.
    start_job(32'h1);
    start = 1'b1;
    drain_job("spam", -1, 1'b1);
    seen = 0;
    repeat (20) begin
      tick();
      if (res_valid || busy) seen++;
    end
    check("spam_no_second_job", 64'(seen), 64'd0);

    // Table write during ISSUE is dropped for this job and the next.
    start_job(32'h1);
    tick(2);
    tbl_write(IF_BANK, 2, 32'hDEAD, 1'b0);
    drain_job("wr_in_issue", -1, 1'b0);
    start_job(32'h1);
    drain_job("wr_dropped", -1, 1'b0);

    // Same-cycle table write and start: job sees the new value.
    tbl_wr    = 1'b1;
    tbl_sel   = IF_BANK;
    tbl_idx   = '0;
    tbl_data  = 32'hBEEF;
    if_sh[0]  = 32'hBEEF;
    cond_word = 32'h1;
    start     = 1'b1;
    push_job(32'h1);
    tick();
    tbl_wr = 1'b0;
    start  = 1'b0;
    drain_job("wr_with_start", -1, 1'b0);

    // Reset in the middle of ISSUE (segment 4).
    start_job(32'h1);
    tick(4);
    check("pre_rst_issue", 64'(dp_issue), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy",  64'(busy), 64'd0);
    check("midrst_outs",  64'({dp_issue, res_valid, res_idx}), 64'd0);
    check("midrst_buses", 64'(dp_if_ref | dp_else_ref | dp_cond | res_data), 64'd0);
    tick();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < int'(NSEG); i++) begin
      if_sh[i]   = '0;
      else_sh[i] = '0;
    end
    seen = 0;
    repeat (10) begin
      tick();
      if (res_valid || busy || dp_issue) seen++;
    end
    check("post_rst_quiet", 64'(seen), 64'd0);
    load_tables();
    start_job(32'h0);
    drain_job("post_rst_job", -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/segment_sched_ctrl.md
SEGMENT_SCHED_CTRL -- requirements
Module: segment_sched_ctrl

Interface
REQ-001 Parameter NSEG, default 8: number of unrolled segments per job (power of two, 2..16).
REQ-002 Parameter DW, default 32: segment data width.
REQ-003 Parameter LAT, default 2: fixed latency in cycles of the shared if/else datapath (1..4).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 tbl_wr  in  1  write strobe for the reference table.
REQ-007 tbl_sel  in  1  table bank: 0 = if-reference, 1 = else-reference.
REQ-008 tbl_idx  in  log2(NSEG)  segment index written.
REQ-009 tbl_data  in  DW  reference word written.
REQ-010 start  in  1  single-cycle job start pulse.
REQ-011 cond_word  in  DW  condition word, captured at accepted start.
REQ-012 busy  out  1  high from accepted start until the last result is consumed.
REQ-013 dp_issue  out  1  one-cycle issue strobe to the shared datapath.
REQ-014 dp_if_ref / dp_else_ref  out  DW each  table entries for the issued segment.
REQ-015 dp_cond  out  DW  captured condition word.
REQ-016 dp_result  in  DW  combined segment result, valid exactly LAT cycles after the matching dp_issue.
REQ-017 res_valid / res_ready  out / in  1 each  result stream handshake.
REQ-018 res_idx / res_data  out  log2(NSEG) / DW  segment index and result.

Function
REQ-019 FSM states IDLE, ISSUE, DRAIN, OUTPUT; reset state IDLE.
REQ-020 IDLE: start accepted only in IDLE; capture cond_word, clear issue and output counters, go to ISSUE, and raise busy on the next cycle.
REQ-021 ISSUE: assert dp_issue on every cycle for segments 0..NSEG-1 in order (NSEG consecutive cycles), driving that segment's table entries; after the last issue go to DRAIN.
REQ-022 Issue tags: a LAT-deep shift register carries (valid, idx) alongside each issue; when a tag exits, dp_result is written into result buffer[idx].
REQ-023 DRAIN: wait until the tag pipe is empty (exactly LAT cycles after the last issue), then go to OUTPUT.
REQ-024 OUTPUT: present buffer entries in index order; res_valid is high, with res_idx/res_data stable, until res_ready; advance only on res_valid and res_ready.
REQ-025 After index NSEG-1 is accepted, go to IDLE; busy drops in the same cycle.
REQ-026 start during ISSUE, DRAIN or OUTPUT is ignored (no queueing).
REQ-027 tbl_wr is accepted only in IDLE; writes in other states are dropped so the table is stable during a job.
REQ-028 tbl_wr and start in the same IDLE cycle: the write lands first, and the job uses the new value.
REQ-029 res_ready held low stalls OUTPUT indefinitely with no loss; the datapath is idle meanwhile.
REQ-030 Counters wrap only through the FSM; no counter exceeds NSEG-1.
REQ-031 Job latency from start to the first res_valid is NSEG+LAT+1 cycles with res_ready high.

Reset
REQ-032 On reset, all outputs go to 0 (busy, dp_issue, res_valid, res_idx, res_data, dp_* buses): state IDLE, tags invalid, counters 0.
REQ-033 Reference table and result buffer are cleared to 0 on reset.
REQ-034 Reset mid-job aborts it. In-flight datapath results arriving after reset deassertion are ignored, because the tags are invalid.

Structure
REQ-035 A shared package holds the FSM state enum, NSEG/DW/LAT defaults, and the table-bank select constants (IF_BANK = 0, ELSE_BANK = 1).
REQ-036 One sub-module, seg_tag_pipe (the LAT-deep valid/idx delay line), is instantiated once; the table, buffer and FSM stay inline.

Verification
REQ-037 Load if[i] = 0x100+i and else[i] = 0x200+i, start with cond 0x1; the datapath model returns the selected reference. Required: eight results, idx 0..7, in order, first res_valid 11 cycles after start (LAT = 2).
REQ-038 Pulse start at each cycle of ISSUE and OUTPUT. Required: only one job runs, and exactly 8 results are produced.
REQ-039 Hold res_ready low 20 cycles at idx 3. Required: res_data/res_idx stay stable, then 3..7 complete, and busy falls after idx 7.
REQ-040 Write tbl idx 2 = 0xDEAD during ISSUE. Required: that job's result 2 is unchanged; the next job sees the old value too, since the write was dropped.
REQ-041 Assert reset at ISSUE segment 4. Required: all outputs are 0 at once, and the late dp_result values are not captured; a new job afterwards gives correct results.
REQ-042 Same-cycle tbl_wr (idx 0 = 0xBEEF) and start. Required: result 0 reflects 0xBEEF.
